// File: rtl/fft_pkg.sv
// Shared FFT helpers: stage geometry and a constant-foldable clog2.
package fft_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // Distance between butterfly partners in a DIF stage.
  function automatic int half_len(input int total_stages, input int stage);
    return 1 << (total_stages - stage - 1);
  endfunction
endpackage

// File: rtl/dif_pair_gather_if.sv
// Serial sample stream in, butterfly pair stream out.
interface dif_pair_gather_if #(parameter int IN_W = 10) (input logic mclk);
  logic            vld, sof;
  logic [IN_W-1:0] I, Q;
  logic            ovld, sop, sync_err;
  logic [IN_W-1:0] LI, LQ, RI, RQ;

  modport master (input mclk, output vld, sof, I, Q,
                  input ovld, sop, sync_err, LI, LQ, RI, RQ);
  modport slave  (input mclk, input vld, sof, I, Q,
                  output ovld, sop, sync_err, LI, LQ, RI, RQ);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, registered read; only the read register is reset.
module sdp_ram import fft_pkg::*; #(
  parameter int W = 20,
  parameter int D = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [clog2(D)-1:0] waddr,
  input  logic [W-1:0]        wdata,
  input  logic                re,
  input  logic [clog2(D)-1:0] raddr,
  output logic [W-1:0]        rdata
);
  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dif_pair_gather.sv
// Buffers the first half of each frame and pairs it with the second half
// so a DIF butterfly sees (x[n], x[n+HALF]) one cycle after x[n+HALF] arrives.
module dif_pair_gather import fft_pkg::*; #(
  parameter int IN_W         = 10,
  parameter int STAGE        = 0,
  parameter int TOTAL_STAGES = 8
) (
  input  logic            mclk,
  input  logic            i_init_n,
  input  logic            i_vld,
  input  logic            i_sof,
  input  logic [IN_W-1:0] i_I,
  input  logic [IN_W-1:0] i_Q,
  output logic            o_vld,
  output logic            o_sop,
  output logic [IN_W-1:0] o_LI,
  output logic [IN_W-1:0] o_LQ,
  output logic [IN_W-1:0] o_RI,
  output logic [IN_W-1:0] o_RQ,
  output logic            o_sync_err
);
  localparam int HALF  = half_len(TOTAL_STAGES, STAGE);
  localparam int IDX_W = clog2(2 * HALF);

  logic [IDX_W-1:0]  idx, eff_idx;
  logic              sof_hit, wr_en, rd_en, first_pair;
  logic [2*IN_W-1:0] wdata, rdata;

  // A frame start always realigns to slot 0, whatever idx says.
  always_comb begin
    sof_hit    = i_vld & i_sof;
    eff_idx    = sof_hit ? '0 : idx;
    wr_en      = i_init_n & i_vld & ~eff_idx[IDX_W-1];
    rd_en      = i_init_n & i_vld &  eff_idx[IDX_W-1];
    first_pair = (eff_idx == IDX_W'(HALF));
    wdata      = {i_I, i_Q};
  end

  generate
    if (HALF > 1) begin : g_ram
      localparam int AW = clog2(HALF);
      sdp_ram #(.W(2 * IN_W), .D(HALF)) u_ram (
        .clk   (mclk),
        .rst_n (i_init_n),
        .we    (wr_en),
        .waddr (eff_idx[AW-1:0]),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (eff_idx[AW-1:0]),
        .rdata (rdata)
      );
    end else begin : g_reg
      logic [2*IN_W-1:0] hold;
      always_ff @(posedge mclk) begin
        if (wr_en) hold <= wdata;
        if (!i_init_n)  rdata <= '0;
        else if (rd_en) rdata <= hold;
      end
    end
  endgenerate

  assign o_LI = rdata[2*IN_W-1:IN_W];
  assign o_LQ = rdata[IN_W-1:0];

  always_ff @(posedge mclk) begin
    if (!i_init_n) begin
      idx        <= '0;
      o_vld      <= 1'b0;
      o_sop      <= 1'b0;
      o_sync_err <= 1'b0;
      o_RI       <= '0;
      o_RQ       <= '0;
    end else begin
      if (i_vld) idx <= eff_idx + IDX_W'(1);
      o_vld      <= rd_en;
      o_sop      <= rd_en & first_pair;
      o_sync_err <= sof_hit & (idx != '0);
      if (rd_en) begin
        o_RI <= i_I;
        o_RQ <= i_Q;
      end
    end
  end
endmodule

// File: tb/tb_dif_pair_gather.sv
// Directed bench: HALF=4 stage driven from a vector table, HALF=1 stage by hand.
module tb_dif_pair_gather;
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic rstn_a, rstn_b;
  int   n_tests = 0, n_fail = 0;

  dif_pair_gather_if #(.IN_W(10)) a_if (.mclk(mclk));
  dif_pair_gather_if #(.IN_W(10)) b_if (.mclk(mclk));

  dif_pair_gather #(.IN_W(10), .STAGE(0), .TOTAL_STAGES(3)) dut_a (
    .mclk(mclk), .i_init_n(rstn_a), .i_vld(a_if.vld), .i_sof(a_if.sof),
    .i_I(a_if.I), .i_Q(a_if.Q), .o_vld(a_if.ovld), .o_sop(a_if.sop),
    .o_LI(a_if.LI), .o_LQ(a_if.LQ), .o_RI(a_if.RI), .o_RQ(a_if.RQ),
    .o_sync_err(a_if.sync_err));

  dif_pair_gather #(.IN_W(10), .STAGE(2), .TOTAL_STAGES(3)) dut_b (
    .mclk(mclk), .i_init_n(rstn_b), .i_vld(b_if.vld), .i_sof(b_if.sof),
    .i_I(b_if.I), .i_Q(b_if.Q), .o_vld(b_if.ovld), .o_sop(b_if.sop),
    .o_LI(b_if.LI), .o_LQ(b_if.LQ), .o_RI(b_if.RI), .o_RQ(b_if.RQ),
    .o_sync_err(b_if.sync_err));

  // One row = one clock: inputs, then outputs expected just after that edge.
  // Q is always -I, so expected LQ/RQ are -L/-R.
  typedef struct {
    logic       vld, sof, rstn;
    int         din;
    logic [2:0] flags;  // {o_vld, o_sop, o_sync_err}
    int         eL, eR;
  } vec_t;

  vec_t tbl[$];
  int   hL, hR;

  function automatic void row(input logic v, input logic s, input logic r,
                              input int d, input logic [2:0] f,
                              input int l, input int rr);
    vec_t t;
    t.vld = v; t.sof = s; t.rstn = r; t.din = d; t.flags = f; t.eL = l; t.eR = rr;
    tbl.push_back(t);
  endfunction

  function automatic logic [42:0] pack_a();
    return {a_if.ovld, a_if.sop, a_if.sync_err, a_if.LI, a_if.LQ, a_if.RI, a_if.RQ};
  endfunction

  function automatic logic [42:0] pack_b();
    return {b_if.ovld, b_if.sop, b_if.sync_err, b_if.LI, b_if.LQ, b_if.RI, b_if.RQ};
  endfunction

  task automatic cmp(input string name, input logic [42:0] got, input logic [42:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step_b(input string name, input logic v, input logic s,
                        input int di, input int dq, input logic [42:0] exp);
    b_if.vld = v; b_if.sof = s; b_if.I = 10'(di); b_if.Q = 10'(dq);
    @(posedge mclk); #1;
    cmp(name, pack_b(), exp);
  endtask

  initial begin
    logic [42:0] exp;
    a_if.vld = 0; a_if.sof = 0; a_if.I = '0; a_if.Q = '0;
    b_if.vld = 0; b_if.sof = 0; b_if.I = '0; b_if.Q = '0;
    rstn_a = 0; rstn_b = 0;

    hL = 0; hR = 0;
    row(0, 0, 0, 0, 3'b000, 0, 0);
    row(0, 0, 0, 0, 3'b000, 0, 0);
    // Continuous frame I=k
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) begin hL = k - 4; hR = k; end
      row(1, 0, 1, k, {k >= 4, k == 4, 1'b0}, hL, hR);
    end
    row(0, 0, 1, 0, 3'b000, hL, hR);
    // Gapped frame; sof on idle cycles must be ignored
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) begin hL = k - 4; hR = k; end
      row(1, 0, 1, k, {k >= 4, k == 4, 1'b0}, hL, hR);
      row(0, 1, 1, 99, 3'b000, hL, hR);
    end
    // Resync at k=2: the sof sample I=10 starts a clean frame
    row(1, 0, 1, 0, 3'b000, hL, hR);
    row(1, 0, 1, 1, 3'b000, hL, hR);
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) begin hL = 10 + k - 4; hR = 10 + k; end
      row(1, k == 0, 1, 10 + k, {k >= 4, k == 4, k == 0}, hL, hR);
    end
    // Mid-frame reset after k=5, input during reset dropped
    for (int k = 0; k < 6; k++) begin
      if (k >= 4) begin hL = k - 4; hR = k; end
      row(1, 0, 1, k, {k >= 4, k == 4, 1'b0}, hL, hR);
    end
    hL = 0; hR = 0;
    row(1, 0, 0, 77, 3'b000, 0, 0);
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) begin hL = 20 + k - 4; hR = 20 + k; end
      row(1, k == 0, 1, 20 + k, {k >= 4, k == 4, 1'b0}, hL, hR);
    end
    row(0, 0, 1, 0, 3'b000, hL, hR);

    foreach (tbl[i]) begin
      a_if.vld = tbl[i].vld; a_if.sof = tbl[i].sof; rstn_a = tbl[i].rstn;
      a_if.I = 10'(tbl[i].din); a_if.Q = 10'(-tbl[i].din);
      if (i == 1) rstn_b = 1;
      @(posedge mclk); #1;
      exp = {tbl[i].flags, 10'(tbl[i].eL), 10'(-tbl[i].eL), 10'(tbl[i].eR), 10'(-tbl[i].eR)};
      cmp($sformatf("a_row%0d", i), pack_a(), exp);
    end
    a_if.vld = 0; a_if.sof = 0;

    // HALF=1: every second sample closes a pair, extremes pass through
    step_b("b_idle",   0, 0,    0,    0, 43'd0);
    step_b("b_s0",     1, 0,    1,   -1, 43'd0);
    step_b("b_p0",     1, 0, -512,  511, {3'b110, 10'd1, 10'h3ff, 10'h200, 10'h1ff});
    step_b("b_s1",     1, 0,  511, -512, {3'b000, 10'd1, 10'h3ff, 10'h200, 10'h1ff});
    step_b("b_p1",     1, 0,    3,    0, {3'b110, 10'h1ff, 10'h200, 10'd3, 10'd0});
    step_b("b_hold",   0, 0,    8,    8, {3'b000, 10'h1ff, 10'h200, 10'd3, 10'd0});
    step_b("b_s2",     1, 0,    5,    5, {3'b000, 10'h1ff, 10'h200, 10'd3, 10'd0});
    step_b("b_resync", 1, 1,    7,    7, {3'b001, 10'h1ff, 10'h200, 10'd3, 10'd0});
    step_b("b_p2",     1, 0,    9,    9, {3'b110, 10'd7, 10'd7, 10'd9, 10'd9});
    step_b("b_end",    0, 0,    0,    0, {3'b000, 10'd7, 10'd7, 10'd9, 10'd9});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
